// File: rtl/mem_burst_ctrl.sv
// rtl/mem_burst_ctrl.sv - burst-to-single-word access controller for a single-port memory
module mem_burst_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,

    input  logic              wr_data_valid,
    output logic              wr_data_ready,
    input  logic [DATA_W-1:0] wr_data,

    output logic              rd_data_valid,
    input  logic              rd_data_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_last,

    output logic              mem_valid,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,

    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_DATA,
        S_WR_MEM,
        S_RD_MEM,
        S_RD_OUT,
        S_DONE
    } state_t;

    state_t              state_q;
    state_t              state_d;

    // Latched command and burst progress.
    logic                wr_q;
    logic                wr_d;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    len_d;
    logic [LEN_W-1:0]    beat_q;
    logic [LEN_W-1:0]    beat_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   addr_d;

    // Next values for the registered outputs.
    logic                cmd_ready_d;
    logic                wr_data_ready_d;
    logic                rd_data_valid_d;
    logic                rd_data_last_d;
    logic [DATA_W-1:0]   rd_data_d;
    logic                mem_valid_d;
    logic                mem_wr_d;
    logic [DATA_W-1:0]   mem_wdata_d;
    logic                busy_d;
    logic                done_d;

    logic                last_beat;

    // The address counter doubles as the memory address register; it only
    // advances between beats, so it is stable for the whole of each request.
    assign mem_addr  = addr_q;
    assign last_beat = (beat_q == len_q);

    // Next-state, datapath and output decode; every output flag is a function
    // of the state being entered so that all outputs leave a flop.
    always_comb begin
        state_d        = state_q;
        wr_d           = wr_q;
        len_d          = len_q;
        beat_d         = beat_q;
        addr_d         = addr_q;
        rd_data_d      = rd_data;
        rd_data_last_d = rd_data_last;
        mem_wdata_d    = mem_wdata;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    wr_d    = cmd_wr;
                    len_d   = cmd_len;
                    addr_d  = cmd_addr;
                    beat_d  = '0;
                    state_d = cmd_wr ? S_WR_DATA : S_RD_MEM;
                end
            end
            S_WR_DATA: begin
                if (wr_data_valid) begin
                    mem_wdata_d = wr_data;
                    state_d     = S_WR_MEM;
                end
            end
            S_WR_MEM: begin
                if (mem_ready) begin
                    if (last_beat) begin
                        state_d = S_DONE;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                        addr_d  = addr_q + 1'b1;
                        state_d = S_WR_DATA;
                    end
                end
            end
            S_RD_MEM: begin
                if (mem_ready) begin
                    rd_data_d      = mem_rdata;
                    rd_data_last_d = last_beat;
                    state_d        = S_RD_OUT;
                end
            end
            S_RD_OUT: begin
                if (rd_data_ready) begin
                    if (rd_data_last) begin
                        state_d = S_DONE;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                        addr_d  = addr_q + 1'b1;
                        state_d = S_RD_MEM;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Last flag only qualifies a word that is actually on offer.
        if (state_d != S_RD_OUT) begin
            rd_data_last_d = 1'b0;
        end

        cmd_ready_d     = (state_d == S_IDLE);
        wr_data_ready_d = (state_d == S_WR_DATA);
        rd_data_valid_d = (state_d == S_RD_OUT);
        mem_valid_d     = (state_d == S_WR_MEM) || (state_d == S_RD_MEM);
        mem_wr_d        = mem_valid_d && wr_d;
        busy_d          = (state_d != S_IDLE);
        done_d          = (state_d == S_DONE);
    end

    // State, counters and registered outputs; reset aborts any burst in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            wr_q          <= 1'b0;
            len_q         <= '0;
            beat_q        <= '0;
            addr_q        <= '0;
            cmd_ready     <= 1'b1;
            wr_data_ready <= 1'b0;
            rd_data_valid <= 1'b0;
            rd_data_last  <= 1'b0;
            rd_data       <= '0;
            mem_valid     <= 1'b0;
            mem_wr        <= 1'b0;
            mem_wdata     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_q          <= wr_d;
            len_q         <= len_d;
            beat_q        <= beat_d;
            addr_q        <= addr_d;
            cmd_ready     <= cmd_ready_d;
            wr_data_ready <= wr_data_ready_d;
            rd_data_valid <= rd_data_valid_d;
            rd_data_last  <= rd_data_last_d;
            rd_data       <= rd_data_d;
            mem_valid     <= mem_valid_d;
            mem_wr        <= mem_wr_d;
            mem_wdata     <= mem_wdata_d;
            busy          <= busy_d;
            done          <= done_d;
        end
    end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb/tb_mem_burst_ctrl.sv - self-checking bench for mem_burst_ctrl
module tb_mem_burst_ctrl;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 10;
    localparam int LEN_W  = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_wr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              wr_data_valid;
    logic              wr_data_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_data_valid;
    logic              rd_data_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_last;
    logic              mem_valid;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    mem_burst_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready), .wr_data(wr_data),
        .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready), .rd_data(rd_data),
        .rd_data_last(rd_data_last),
        .mem_valid(mem_valid), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy(busy), .done(done)
    );

    // Memory behind the controller, with a programmable ready latency.
    logic [DATA_W-1:0] dut_mem [DEPTH];
    logic [DATA_W-1:0] ref_mem [DEPTH];
    int  wait_cnt    = 0;
    int  rand_delay  = 0;
    int  fixed_delay = 0;
    bit  mem_rand    = 1'b0;
    int  cyc         = 0;

    assign mem_ready = (wait_cnt >= (mem_rand ? rand_delay : fixed_delay));
    assign mem_rdata = dut_mem[mem_addr];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_valid && mem_ready && mem_wr) dut_mem[mem_addr] <= mem_wdata;
        if (reset || !mem_valid || mem_ready) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
        if (mem_valid && mem_ready) rand_delay <= int'($urandom_range(0, 3));
    end

    // Transaction logs and protocol-rule violation counters, sampled mid-cycle.
    int                log_addr [$];
    bit                log_wr   [$];
    logic [DATA_W-1:0] log_data [$];
    logic [DATA_W-1:0] rd_vals  [$];
    bit                rd_lasts [$];
    int done_cnt = 0, stab_err = 0, rd_stab_err = 0, overlap_err = 0, done_wide_err = 0;
    logic              p_mv = 0, p_mr = 0, p_mw = 0, p_rv = 0, p_rr = 0, p_rl = 0, p_done = 0;
    logic [ADDR_W-1:0] p_ma = '0;
    logic [DATA_W-1:0] p_md = '0, p_rd = '0;

    always @(negedge clk) begin
        if (!reset) begin
            if (mem_valid && mem_ready) begin
                log_addr.push_back(int'(mem_addr));
                log_wr.push_back(mem_wr);
                log_data.push_back(mem_wdata);
            end
            if (rd_data_valid && rd_data_ready) begin
                rd_vals.push_back(rd_data);
                rd_lasts.push_back(rd_data_last);
            end
            if (done) done_cnt <= done_cnt + 1;
            if (p_mv && !p_mr && !(mem_valid && mem_addr == p_ma && mem_wdata == p_md && mem_wr == p_mw))
                stab_err <= stab_err + 1;
            if (p_rv && !p_rr && !(rd_data_valid && rd_data == p_rd && rd_data_last == p_rl))
                rd_stab_err <= rd_stab_err + 1;
            if (mem_valid && rd_data_valid) overlap_err <= overlap_err + 1;
            if (done && p_done) done_wide_err <= done_wide_err + 1;
        end
        p_mv <= reset ? 1'b0 : mem_valid;
        p_mr <= mem_ready;
        p_mw <= mem_wr;
        p_ma <= mem_addr;
        p_md <= mem_wdata;
        p_rv <= reset ? 1'b0 : rd_data_valid;
        p_rr <= rd_data_ready;
        p_rd <= rd_data;
        p_rl <= rd_data_last;
        p_done <= reset ? 1'b0 : done;
    end

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] wbuf [256];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_cmd(input bit wr, input int addr, input int len, output bit ok);
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = ADDR_W'(addr);
        cmd_len   = LEN_W'(len);
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            ok = cmd_ready;
            tick();
            if (ok) break;
        end
    endtask

    task automatic push_word(input logic [DATA_W-1:0] d, output bit ok);
        wr_data_valid = 1'b1;
        wr_data       = d;
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            ok = wr_data_ready;
            tick();
            if (ok) break;
        end
    endtask

    // One burst end to end, then its transactions checked against the
    // word-level model: addresses base+i mod DEPTH, data from wbuf / ref_mem.
    task automatic run_burst(input bit wr, input int addr, input int len, input int gap,
                             input int hold_idx, input int hold_len, input bit rnd,
                             input bit stray, output int cycles);
        int n;
        int c0;
        int dc0;
        int g;
        int h;
        int bad_a;
        int bad_d;
        int bad_l;
        int a;
        bit ok;
        n = len + 1;
        cycles = -1;
        log_addr.delete(); log_wr.delete(); log_data.delete();
        rd_vals.delete(); rd_lasts.delete();
        dc0 = done_cnt;
        rd_data_ready = 1'b1;

        issue_cmd(wr, addr, len, ok);
        check("cmd_accept", {63'd0, ok}, 64'd1);
        if (!ok) begin
            cmd_valid = 1'b0;
            return;
        end
        c0 = cyc;
        if (stray) begin
            cmd_wr   = ~wr;
            cmd_addr = ADDR_W'(addr + 37);
        end else begin
            cmd_valid = 1'b0;
        end

        for (int i = 0; i < n; i++) begin
            if (wr) begin
                wr_data_valid = 1'b0;
                g = rnd ? int'($urandom_range(0, 2)) : gap;
                repeat (g) tick();
                push_word(wbuf[i], ok);
                if (!ok) begin
                    check("wr_word_accept_timeout", 64'd0, 64'd1);
                    wr_data_valid = 1'b0;
                    cmd_valid = 1'b0;
                    return;
                end
            end else begin
                h = rnd ? int'($urandom_range(0, 2)) : ((i == hold_idx) ? hold_len : 0);
                if (h > 0) rd_data_ready = 1'b0;
                ok = 1'b0;
                for (int t = 0; t < 100; t++) begin
                    if (rd_data_valid) begin
                        ok = 1'b1;
                        break;
                    end
                    tick();
                end
                if (!ok) begin
                    check("rd_word_timeout", 64'd0, 64'd1);
                    rd_data_ready = 1'b1;
                    cmd_valid = 1'b0;
                    return;
                end
                repeat (h) tick();
                rd_data_ready = 1'b1;
                tick();
            end
        end
        wr_data_valid = 1'b0;

        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        cmd_valid = 1'b0;
        check("done_seen", {63'd0, ok}, 64'd1);
        cycles = cyc - c0;
        tick();
        check("idle_after_done", {61'd0, busy, cmd_ready, done}, 64'b010);

        check("mem_txn_count", log_addr.size(), n);
        bad_a = 0; bad_d = 0; bad_l = 0;
        for (int i = 0; i < n; i++) begin
            a = (addr + i) % DEPTH;
            if (i < log_addr.size()) begin
                if (log_addr[i] != a || log_wr[i] != wr) bad_a++;
                if (wr && log_data[i] !== wbuf[i]) bad_d++;
            end
            if (!wr && i < rd_vals.size()) begin
                if (rd_vals[i] !== ref_mem[a]) bad_d++;
                if (rd_lasts[i] != (i == n - 1)) bad_l++;
            end
        end
        check("addr_sequence", bad_a, 0);
        check(wr ? "write_data" : "read_data", bad_d, 0);
        if (!wr) begin
            check("read_word_count", rd_vals.size(), n);
            check("read_last_flag", bad_l, 0);
        end
        check("done_pulse_count", done_cnt - dc0, 1);
        if (wr) for (int i = 0; i < n; i++) ref_mem[(addr + i) % DEPTH] = wbuf[i];
    endtask

    typedef struct {
        bit wr;
        int addr;
        int len;
        int delay;
        int gap;
        int hold_idx;
        int hold_len;
        bit stray;
        bit pattern;
        int exp_cycles;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  cycles;
        int  bad;
        bit  ok;
        int  dc0;
        bit  wr;
        int  a;
        int  l;

        //            wr addr  len dly gap hidx hlen stray pat  cycles
        vecs[0] = '{1'b1,    5,  3,  0,  0,  -1,  0, 1'b0, 1'b1,  8};
        vecs[1] = '{1'b0,    5,  3,  0,  0,  -1,  0, 1'b1, 1'b0,  8};
        vecs[2] = '{1'b0,    5,  3,  0,  0,   1,  5, 1'b0, 1'b0, 13};
        vecs[3] = '{1'b1, 1022,  2,  0,  0,  -1,  0, 1'b0, 1'b0,  6};
        vecs[4] = '{1'b0, 1022,  2,  0,  0,  -1,  0, 1'b0, 1'b0,  6};
        vecs[5] = '{1'b1,  100,  4,  3,  2,  -1,  0, 1'b0, 1'b0, 27};
        vecs[6] = '{1'b0,  100,  4,  3,  0,  -1,  0, 1'b0, 1'b0, 25};

        for (int i = 0; i < DEPTH; i++) begin
            dut_mem[i] = '0;
            ref_mem[i] = '0;
        end
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_data_valid = 1'b0; wr_data = '0; rd_data_ready = 1'b1;
        tick();
        tick();
        check("reset_flags", {56'd0, cmd_ready, wr_data_ready, rd_data_valid, rd_data_last,
                              mem_valid, mem_wr, busy, done}, 64'b1000_0000);
        check("reset_mem_addr", mem_addr, 0);
        check("reset_mem_wdata", mem_wdata, 0);
        check("reset_rd_data", rd_data, 0);
        reset = 1'b0;
        tick();

        // Fill the whole memory with four maximum-length bursts.
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 256; i++) wbuf[i] = DATA_W'($urandom);
            run_burst(1'b1, k * 256, 255, 0, -1, 0, 1'b0, 1'b0, cycles);
            check("max_burst_cycles", cycles, 512);
        end
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (dut_mem[i] !== ref_mem[i]) bad++;
        check("fill_mem_compare", bad, 0);

        for (int v = 0; v < 7; v++) begin
            fixed_delay = vecs[v].delay;
            mem_rand = 1'b0;
            for (int i = 0; i <= vecs[v].len; i++)
                wbuf[i] = vecs[v].pattern ? DATA_W'((i + 1) * 16'h1111) : DATA_W'($urandom);
            run_burst(vecs[v].wr, vecs[v].addr, vecs[v].len, vecs[v].gap, vecs[v].hold_idx,
                      vecs[v].hold_len, 1'b0, vecs[v].stray, cycles);
            check("vector_cycles", cycles, vecs[v].exp_cycles);
        end

        // Reset while the third word of an 8-word write is waiting on memory.
        fixed_delay = 3;
        mem_rand = 1'b0;
        dc0 = done_cnt;
        issue_cmd(1'b1, 200, 7, ok);
        cmd_valid = 1'b0;
        check("abort_cmd_accept", {63'd0, ok}, 64'd1);
        push_word(16'hA0A0, ok);
        push_word(16'hA1A1, ok);
        push_word(16'hA2A2, ok);
        wr_data_valid = 1'b0;
        check("abort_beat2_request", {53'd0, mem_valid, mem_wr, mem_addr}, {53'd0, 2'b11, 10'd202});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_flags", {56'd0, cmd_ready, wr_data_ready, rd_data_valid, rd_data_last,
                              mem_valid, mem_wr, busy, done}, 64'b1000_0000);
        check("abort_mem_addr", mem_addr, 0);
        repeat (4) tick();
        check("abort_no_done", done_cnt - dc0, 0);
        ref_mem[200] = 16'hA0A0;
        ref_mem[201] = 16'hA1A1;
        fixed_delay = 0;
        run_burst(1'b0, 200, 3, 0, -1, 0, 1'b0, 1'b0, cycles);
        check("post_abort_cycles", cycles, 8);

        // Randomized bursts with random memory latency, data gaps and backpressure.
        mem_rand = 1'b1;
        for (int k = 0; k < 25; k++) begin
            wr = 1'($urandom_range(0, 1));
            a  = int'($urandom_range(0, DEPTH - 1));
            l  = (k % 8 == 7) ? int'($urandom_range(16, 60)) : int'($urandom_range(0, 15));
            for (int i = 0; i <= l; i++) wbuf[i] = DATA_W'($urandom);
            run_burst(wr, a, l, 0, -1, 0, 1'b1, (k % 5 == 0), cycles);
        end

        check("mem_request_stability", stab_err, 0);
        check("rd_data_stability", rd_stab_err, 0);
        check("mem_valid_with_rd_valid", overlap_err, 0);
        check("done_single_cycle", done_wide_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_burst_ctrl.md
Name: mem_burst_ctrl

Overview:
Burst access controller that sits directly upstream of Single_port_Memory and drives its valid/WR/addr/data_in port. Accepts one command at a time: a write or read burst from a base address for N consecutive words. Write data arrives on a valid/ready stream and read data leaves on one. Converts each burst into single-word memory transactions, holding every request until the memory returns ready.

Parameters:
DATA_W, 16, data word width (matches memory data_in/data_out)
ADDR_W, 10, memory address width
LEN_W, 8, burst length field width; burst length = cmd_len + 1 (1..2^LEN_W words)

Ports:
clk  input  1  single clock, all logic on rising edge
reset  input  1  synchronous, active-high
cmd_valid  input  1  command offered
cmd_ready  output  1  controller can accept a command (IDLE only)
cmd_wr  input  1  1 = write burst, 0 = read burst
cmd_addr  input  ADDR_W  burst base address
cmd_len  input  LEN_W  burst length minus one
wr_data_valid  input  1  write word offered
wr_data_ready  output  1  controller accepts write word
wr_data  input  DATA_W  write word
rd_data_valid  output  1  read word available
rd_data_ready  input  1  consumer accepts read word
rd_data  output  DATA_W  read word
rd_data_last  output  1  qualifies the final read word of the burst
mem_valid  output  1  to memory valid
mem_wr  output  1  to memory WR
mem_addr  output  ADDR_W  to memory addr
mem_wdata  output  DATA_W  to memory data_in
mem_rdata  input  DATA_W  from memory data_out
mem_ready  input  1  from memory ready; transaction completes in any cycle where mem_valid & mem_ready
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at burst completion

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port name reset.
- All outputs registered. After any edge with reset=1: state IDLE; cmd_ready=1; all other outputs 0; address/beat counters 0.
- States: IDLE, WR_DATA, WR_MEM, RD_MEM, RD_OUT, DONE.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch cmd_wr, cmd_addr, cmd_len; beat counter=0; go WR_DATA (write) or RD_MEM (read). cmd_ready drops the next cycle.
- WR_DATA: wr_data_ready=1. On wr_data_valid, register wr_data into mem_wdata; go WR_MEM.
- WR_MEM: mem_valid=1, mem_wr=1; mem_addr, mem_wdata held stable. On mem_ready: if beat==len go DONE, else beat+1, addr+1, go WR_DATA.
- RD_MEM: mem_valid=1, mem_wr=0. On mem_ready: capture mem_rdata into rd_data, rd_data_valid=1, rd_data_last=(beat==len); go RD_OUT.
- RD_OUT: mem_valid=0. rd_data, rd_data_valid, and rd_data_last held until rd_data_ready. On accept: rd_data_valid=0; if last go DONE, else beat+1, addr+1, go RD_MEM.
- DONE: done=1 for exactly one cycle, busy=1; then IDLE.
- mem_valid is deasserted in every state other than WR_MEM and RD_MEM; never asserted while rd_data_valid=1.
- Address increment wraps modulo 2^ADDR_W (e.g. 1023 -> 0 at ADDR_W=10); the burst continues across the wrap.
- Best-case throughput with mem_ready tied high: write 2 cycles/word, read 2 cycles/word.
- wr_data_valid outside WR_DATA is ignored (wr_data_ready=0). Commands presented while busy are not accepted.
- Reset mid-burst: abort at that edge, no done pulse, memory-side outputs 0 the following cycle, remaining beats discarded.
- Beat counter is LEN_W bits; cmd_len = 2^LEN_W-1 yields 256 words at LEN_W=8 with no counter overflow before completion.

Test Plan:
- Write burst: addr=5, len=3 (4 words), data 0x1111,0x2222,0x3333,0x4444, mem_ready high -> mem writes at 5,6,7,8 with matching data; done pulses once; busy low the cycle after.
- Read back addr=5, len=3, rd_data_ready high -> rd_data 0x1111..0x4444 in order; rd_data_last only on 0x4444; done once.
- Read burst with rd_data_ready held low 5 cycles on the second word -> rd_data stable, no new mem_valid until accept, no word lost or duplicated.
- Write burst at addr=1022, len=2 -> memory addresses 1022, 1023, 0; readback matches.
- mem_ready delayed 3 cycles per beat plus wr_data_valid gaps -> mem_valid/addr/wdata held stable throughout; correct data at each address.
- Reset asserted during beat 2 of a len=7 write -> next cycle: IDLE, cmd_ready=1, mem_valid=0, no done; new command then runs normally.
